uart_line_ctrl: RTL

- Line-editing terminal controller between the UART RX FIFO (uart_rx_buf) and the UART TX FIFO (uart_tx_buf).
- Pops received bytes, echoes them with terminal semantics (backspace erase, CR→CRLF, BEL on overflow) and assembles a line buffer.
- On CR, presents the completed line to a downstream consumer through a valid/ack handshake.
- Replaces the bare echo loop as the sequencer that owns both UART FIFO handshakes.

---
 rtl/uart_line_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_line_ctrl.sv
// -----------------------------------------------------------------------------
// uart_line_ctrl
//
// Line-editing terminal sequencer that sits between the UART RX FIFO and the
// UART TX FIFO. It pops received bytes, echoes them with terminal semantics
// (backspace erase, CR -> CRLF, BEL when the line is full), and assembles a
// line buffer. On CR the completed line is handed to a consumer through a
// line_valid / line_ack handshake.
//
// Build option:
//   UART_LINE_PROMPT_EN  When defined, PROMPT_CHAR is emitted after reset and
//                        after every line_ack, before RX is popped again.
//
// Parameters:
//   LINE_LEN     line buffer capacity in bytes (1..255)
//   PROMPT_CHAR  prompt byte (used only with UART_LINE_PROMPT_EN)
//
// Ports:
//   clk, rst_n    system clock (posedge), asynchronous active-low reset
//   rx_get        one-cycle pop strobe to the RX FIFO
//   rx_data       RX FIFO head byte (first-word-fall-through)
//   rx_empty      RX FIFO empty
//   tx_put        one-cycle push strobe to the TX FIFO
//   tx_data       byte pushed with tx_put
//   tx_empty      TX FIFO empty; a byte is pushed only while it is 1
//   line_valid    completed line available, held until line_ack
//   line_len      byte count of the completed line
//   line_rd_addr  line buffer read address
//   line_rd_data  combinational buffer read, 8'h00 beyond LINE_LEN
//   line_ack      consumer releases the line (ignored unless line_valid)
//   overflow      sticky: a printable byte was dropped in the current line
// -----------------------------------------------------------------------------
module uart_line_ctrl #(
  parameter int         LINE_LEN    = 64,
  parameter logic [7:0] PROMPT_CHAR = 8'h3E
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       rx_get,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       tx_put,
  output logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       line_valid,
  output logic [7:0] line_len,
  input  logic [7:0] line_rd_addr,
  output logic [7:0] line_rd_data,
  input  logic       line_ack,
  output logic       overflow
);

  localparam int         AW      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [7:0] LEN_MAX = 8'(LINE_LEN);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLASS  = 3'd1;
  localparam logic [2:0] ST_EMIT   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_LINE   = 3'd4;
`ifdef UART_LINE_PROMPT_EN
  localparam logic [2:0] ST_PROMPT = 3'd5;
  // Reset and line release both pass through the prompt before RX is popped.
  localparam logic [2:0] ST_START  = ST_PROMPT;
`else
  localparam logic [2:0] ST_START  = ST_IDLE;
`endif

  logic [2:0]      state;
  logic [7:0]      rx_byte;     // byte popped in ST_IDLE, classified in ST_CLASS
  logic [7:0]      count;       // bytes currently held in the line
  logic [2:0][7:0] seq;         // pending echo bytes, seq[0] goes out next
  logic [1:0]      seq_cnt;     // number of valid entries in seq
  logic            line_pend;   // CRLF in flight; present the line once drained
  logic [7:0]      buf_mem [2**AW];

  logic is_print;
  logic is_bs;
  logic is_cr;
  logic has_room;
  logic buf_we;

  assign is_print = (rx_byte >= 8'h20) && (rx_byte <= 8'h7E);
  assign is_bs    = (rx_byte == 8'h08) || (rx_byte == 8'h7F);
  assign is_cr    = (rx_byte == 8'h0D);
  assign has_room = (count < LEN_MAX);
  assign buf_we   = (state == ST_CLASS) && is_print && has_room;

  // NOTE: the line buffer is plain storage with no reset; its contents
  // survive reset and are only meaningful below line_len.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[count[AW-1:0]] <= rx_byte;
  end

  assign line_rd_data = (line_rd_addr < LEN_MAX) ? buf_mem[line_rd_addr[AW-1:0]]
                                                 : 8'h00;

  // NOTE: all sequencer state uses non-blocking assignments so every branch
  // reads the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_START;
      rx_get     <= 1'b0;
      tx_put     <= 1'b0;
      tx_data    <= 8'h00;
      line_valid <= 1'b0;
      line_len   <= 8'h00;
      overflow   <= 1'b0;
      count      <= 8'h00;
      rx_byte    <= 8'h00;
      seq        <= '0;
      seq_cnt    <= 2'd0;
      line_pend  <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      rx_get <= 1'b0;
      tx_put <= 1'b0;

      case (state)
`ifdef UART_LINE_PROMPT_EN
        ST_PROMPT: begin
          seq     <= {8'h00, 8'h00, PROMPT_CHAR};
          seq_cnt <= 2'd1;
          state   <= ST_EMIT;
        end
`endif
        ST_IDLE: begin
          if (!rx_empty) begin
            rx_get  <= 1'b1;
            rx_byte <= rx_data;
            state   <= ST_CLASS;
          end
        end

        ST_CLASS: begin
          if (is_print) begin
            if (has_room) begin
              count <= count + 8'd1;
              seq   <= {8'h00, 8'h00, rx_byte};
            end else begin
              overflow <= 1'b1;
              seq      <= {8'h00, 8'h00, 8'h07};
            end
            seq_cnt <= 2'd1;
            state   <= ST_EMIT;
          end else if (is_bs) begin
            if (count != 8'h00) begin
              count   <= count - 8'd1;
              seq     <= {8'h08, 8'h20, 8'h08};
              seq_cnt <= 2'd3;
              state   <= ST_EMIT;
            end else begin
              state <= ST_IDLE;
            end
          end else if (is_cr) begin
            seq       <= {8'h00, 8'h0A, 8'h0D};
            seq_cnt   <= 2'd2;
            line_pend <= 1'b1;
            state     <= ST_EMIT;
          end else begin
            state <= ST_IDLE;  // LF and all other bytes are swallowed
          end
        end

        ST_EMIT: begin
          if (tx_empty) begin
            tx_put  <= 1'b1;
            tx_data <= seq[0];
            seq     <= {8'h00, seq[2], seq[1]};
            seq_cnt <= seq_cnt - 2'd1;
            state   <= ST_GAP;
          end
        end

        // One idle cycle after every put so tx_empty reflects the push
        // before it is sampled again.
        ST_GAP: begin
          if (seq_cnt != 2'd0) begin
            state <= ST_EMIT;
          end else if (line_pend) begin
            line_pend  <= 1'b0;
            line_valid <= 1'b1;
            line_len   <= count;
            state      <= ST_LINE;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_LINE: begin
          if (line_ack) begin
            line_valid <= 1'b0;
            count      <= 8'h00;
            overflow   <= 1'b0;
            state      <= ST_START;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
